// File: rtl/param_direct_cache.sv
// Parametrised direct-mapped, write-back, write-allocate cache with one word per line.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module param_direct_cache #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              hit,
    output logic              miss,
    output logic              ready,
    output logic              resp_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WB      = 2'd1,
        S_FILL    = 2'd2,
        S_INSTALL = 2'd3
    } state_t;

    state_t              r_state;
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [DATA_W-1:0]   r_line [LINES];
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_is_wr;
    logic [DATA_W-1:0]   r_rdout;
    logic                r_hit;
    logic                r_miss;
    logic                r_ready;
    logic                r_resp;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_lat_idx;
    logic [TAG_W-1:0]    w_lat_tag;
    logic                w_accept;
    logic                w_hit;
    logic                w_arr_we;
    logic [INDEX_W-1:0]  w_arr_idx;
    logic [TAG_W-1:0]    w_arr_tag;
    logic [DATA_W-1:0]   w_arr_data;

    assign w_idx     = addr[INDEX_W-1:0];
    assign w_tag     = addr[ADDR_W-1:INDEX_W];
    assign w_lat_idx = r_addr[INDEX_W-1:0];
    assign w_lat_tag = r_addr[ADDR_W-1:INDEX_W];
    assign w_accept  = (r_state == S_IDLE) && (rd ^ wr);
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Select the single tag/data array write for this cycle.
    always_comb begin
        w_arr_we   = 1'b0;
        w_arr_idx  = w_lat_idx;
        w_arr_tag  = w_lat_tag;
        w_arr_data = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept && wr && w_hit) begin
                    w_arr_we   = 1'b1;
                    w_arr_idx  = w_idx;
                    w_arr_tag  = w_tag;
                    w_arr_data = w_data;
                end else begin
                    w_arr_we   = 1'b0;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    w_arr_we   = 1'b1;
                    w_arr_data = mem_rdata;
                end else begin
                    w_arr_we   = 1'b0;
                end
            end
            S_INSTALL: w_arr_we = 1'b1;
            default:   w_arr_we = 1'b0;
        endcase
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_tag[w_arr_idx]  <= w_arr_tag;
            r_line[w_arr_idx] <= w_arr_data;
        end
    end

    // Control FSM, valid/dirty state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_wr     <= 1'b0;
            r_rdout     <= '0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_ready     <= 1'b1;
            r_resp      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            r_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= addr;
                        r_wdata <= w_data;
                        r_is_wr <= wr;
                        if (w_hit) begin
                            r_hit  <= 1'b1;
                            r_resp <= 1'b1;
                            if (rd) begin
                                r_rdout <= r_line[w_idx];
                            end else begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else begin
                            r_miss  <= 1'b1;
                            r_ready <= 1'b0;
                            // A dirty victim must reach memory before the line is reused.
                            if (r_valid[w_idx] && r_dirty[w_idx]) begin
                                r_state     <= S_WB;
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= {r_tag[w_idx], w_idx};
                                r_mem_wdata <= r_line[w_idx];
                            end else if (rd) begin
                                r_state    <= S_FILL;
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= addr;
                            end else begin
                                r_state <= S_INSTALL;
                            end
                        end
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        if (r_is_wr) begin
                            r_state   <= S_INSTALL;
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                        end else begin
                            r_state    <= S_FILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= r_addr;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        r_valid[w_lat_idx] <= 1'b1;
                        r_dirty[w_lat_idx] <= 1'b0;
                        r_rdout            <= mem_rdata;
                        r_resp             <= 1'b1;
                        r_mem_req          <= 1'b0;
                        r_ready            <= 1'b1;
                        r_state            <= S_IDLE;
                    end
                end
                S_INSTALL: begin
                    r_valid[w_lat_idx] <= 1'b1;
                    r_dirty[w_lat_idx] <= 1'b1;
                    r_resp             <= 1'b1;
                    r_ready            <= 1'b1;
                    r_state            <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b1;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating counters advance on each registered hit/miss pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= 16'd0;
            r_miss_cnt <= 16'd0;
        end else begin
            if (r_hit && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (r_miss && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = 16'd0;
    assign miss_cnt = 16'd0;
`endif

    assign r_data     = r_rdout;
    assign hit        = r_hit;
    assign miss       = r_miss;
    assign ready      = r_ready;
    assign resp_valid = r_resp;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_param_direct_cache.sv
// Scoreboard bench for param_direct_cache: directed requests push expected lookups,
// responses and memory transactions; a negedge monitor pops and compares them.
module tb_param_direct_cache;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd, wr;
    logic [5:0] addr;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       hit, miss, ready, resp_valid;
    logic       mem_req, mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_ack;
    logic [15:0] hit_cnt, miss_cnt;

    typedef struct packed { logic is_rd; logic [7:0] data; } resp_t;
    typedef struct packed { logic we; logic [5:0] addr; logic [7:0] wdata; } memop_t;

    logic   exp_look[$];
    resp_t  exp_resp[$];
    memop_t exp_mem[$];
    int     n_cmp  = 0;
    int     n_fail = 0;
    logic [7:0] mem [64];
    int     mcnt;
    logic [15:0] exp_hc, exp_mc;

    param_direct_cache #(.ADDR_W(6), .DATA_W(8), .INDEX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr), .w_data(w_data),
        .r_data(r_data), .hit(hit), .miss(miss), .ready(ready), .resp_valid(resp_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: acks two cycles after it sees mem_req.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h40 + 8'(i);
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        mcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_ack = 1'b0;
                mcnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                mcnt = mem_req ? 1 : 0;
            end else if (mem_req) begin
                mcnt++;
                if (mcnt >= 2) begin
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    mem_ack = 1'b1;
                    mcnt = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: compare every DUT pulse and memory handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hit || miss) begin
                if (exp_look.size() == 0) begin
                    check("unexpected_lookup", {30'd0, hit, miss}, 32'd0);
                end else begin
                    logic e;
                    e = exp_look.pop_front();
                    check("lookup_hit_miss", {30'd0, hit, miss}, e ? 32'd2 : 32'd1);
                end
            end
            if (resp_valid) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    resp_t r;
                    r = exp_resp.pop_front();
                    if (r.is_rd) check("read_data", {24'd0, r_data}, {24'd0, r.data});
                end
            end
            if (mem_req && mem_ack) begin
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem", {25'd0, mem_we, mem_addr}, 32'd0);
                end else begin
                    memop_t m;
                    m = exp_mem.pop_front();
                    check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    check("mem_addr", {26'd0, mem_addr}, {26'd0, m.addr});
                    if (m.we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, m.wdata});
                end
            end
        end
    end

    task automatic push_mem(input logic we, input logic [5:0] a, input logic [7:0] d);
        memop_t m;
        m.we = we; m.addr = a; m.wdata = d;
        exp_mem.push_back(m);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 60; k++) begin
            if (ready && exp_look.size() == 0 && exp_resp.size() == 0 && exp_mem.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (k == 60) check("request_timeout", 32'd1, 32'd0);
    endtask

    task automatic req(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d,
                       input logic exp_hit, input logic [7:0] exp_rd);
        resp_t e;
        e.is_rd = r; e.data = exp_rd;
        exp_look.push_back(exp_hit);
        exp_resp.push_back(e);
        rd = r; wr = w; addr = a; w_data = d;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
        wait_done();
    endtask

    task automatic check_reset_state();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_r_data", {24'd0, r_data}, 32'd0);
        check("rst_pulses", {29'd0, hit, miss, resp_valid}, 32'd0);
        check("rst_mem_req", {30'd0, mem_req, mem_we}, 32'd0);
        check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_counters", {hit_cnt, miss_cnt}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 6'd0; w_data = 8'd0;
        #22;
        rst_n = 1'b1;
        check_reset_state();

        // Cold write miss installs without memory traffic, then a read hit.
        req(1'b0, 1'b1, 6'd5, 8'hA5, 1'b0, 8'h00);
        req(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 8'hA5);

        // Conflicting writes on index 1 evict the dirty line.
        req(1'b0, 1'b1, 6'd25, 8'h3C, 1'b0, 8'h00);
        push_mem(1'b1, 6'd25, 8'h3C);
        req(1'b0, 1'b1, 6'd9, 8'hC3, 1'b0, 8'h00);

        // Read miss with dirty victim: write-back then fill.
        push_mem(1'b1, 6'd9, 8'hC3);
        push_mem(1'b0, 6'd25, 8'h00);
        req(1'b1, 1'b0, 6'd25, 8'h00, 1'b0, 8'h3C);

`ifdef CACHE_STATS_EN
        exp_hc = 16'd1; exp_mc = 16'd4;
`else
        exp_hc = 16'd0; exp_mc = 16'd0;
`endif
        check("hit_cnt", {16'd0, hit_cnt}, {16'd0, exp_hc});
        check("miss_cnt", {16'd0, miss_cnt}, {16'd0, exp_mc});

        // Filled line is clean: evicting it needs no write-back.
        push_mem(1'b0, 6'd9, 8'h00);
        req(1'b1, 1'b0, 6'd9, 8'h00, 1'b0, 8'hC3);

        // rd and wr together are ignored.
        rd = 1'b1; wr = 1'b1; addr = 6'd5; w_data = 8'hFF;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
        check("both_ready", {31'd0, ready}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("both_no_state", {31'd0, ready}, 32'd1);
        req(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 8'hA5);

        // Reset in the middle of a fill aborts the request.
        exp_look.push_back(1'b0);
        rd = 1'b1; addr = 6'd17;
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(negedge clk);
        #2;
        check("fill_req_active", {30'd0, mem_req, mem_we}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("reset_drops_req", {31'd0, mem_req}, 32'd0);
        exp_look.delete();
        exp_resp.delete();
        exp_mem.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        check_reset_state();
        push_mem(1'b0, 6'd5, 8'h00);
        req(1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 8'h45);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
